// File: rtl/instruction_sequencer_if.sv
// Program-load, control and issue signals between the sequencer and whatever
// drives it. The master modport loads and starts the program; the slave modport issues it.
interface instruction_sequencer_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [17:0]   prog_wdata;
    logic          start;
    logic          stall;
    logic [8:0]    func_out;
    logic [7:0]    data_out;
    logic          issue_valid;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc_out;

    modport master (
        output prog_we, prog_addr, prog_wdata, start, stall,
        input  func_out, data_out, issue_valid, busy, done, pc_out
    );

    modport slave (
        input  prog_we, prog_addr, prog_wdata, start, stall,
        output func_out, data_out, issue_valid, busy, done, pc_out
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Small loadable program store that issues one {imm8, func9} word per cycle
// to the 8-bit processor until it reaches a halt word or the last address.
module instruction_sequencer #(
    parameter int         DEPTH    = 16,
    parameter int         AW       = 4,
    parameter logic [8:0] NOP_FUNC = 9'h000
) (
    input logic                      clock,
    input logic                      resetn,
    instruction_sequencer_if.slave   bus
);

    typedef struct packed {
        logic       halt;
        logic [7:0] imm;
        logic [8:0] func;
    } word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    word_t         mem [DEPTH];
    word_t         rd_word;
    logic [AW-1:0] rd_addr;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          halt_q, halt_d;
    logic [8:0]    func_q, func_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // NOTE: the program store has no reset; that keeps it a plain RAM and lets a
    // program survive a reset pulse.
    always_ff @(posedge clock) begin
        if (bus.prog_we && !busy_q) begin
            mem[bus.prog_addr] <= word_t'(bus.prog_wdata);
        end
    end

    // Read address is the word wanted at the next edge; a write on that same edge
    // lands after this read, so a start alongside a write to 0 sees the old word.
    assign rd_addr = (state_q == S_RUN) ? pc_q + AW'(1) : '0;
    assign rd_word = mem[rd_addr];

    // NOTE: every *_d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        halt_d  = halt_q;
        func_d  = func_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    halt_d  = rd_word.halt;
                    func_d  = rd_word.func;
                    data_d  = rd_word.imm;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (halt_q || pc_q == AW'(DEPTH - 1)) begin
                        state_d = S_DONE;
                        halt_d  = 1'b0;
                        func_d  = NOP_FUNC;
                        data_d  = '0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        pc_d   = pc_q + AW'(1);
                        halt_d = rd_word.halt;
                        func_d = rd_word.func;
                        data_d = rd_word.imm;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            func_q  <= NOP_FUNC;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            func_q  <= func_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.func_out    = func_q;
    assign bus.data_out    = data_q;
    assign bus.issue_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pc_out      = pc_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: a program model predicts each issued
// word, and the issues observed on the bus are popped and compared in order.
module tb_instruction_sequencer;

    localparam int         DEPTH = 16;
    localparam int         AW    = 4;
    localparam logic [8:0] NOP   = 9'h000;

    typedef struct packed {
        logic [8:0]    func;
        logic [7:0]    data;
        logic [AW-1:0] pc;
    } issue_t;

    logic clk = 1'b0;
    logic rst_n;

    issue_t      exp_q[$];
    logic [17:0] mem_model [DEPTH];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    instruction_sequencer_if #(.AW(AW)) bus ();

    instruction_sequencer #(.DEPTH(DEPTH), .AW(AW), .NOP_FUNC(NOP)) dut (
        .clock  (clk),
        .resetn (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.issue_valid), 0);
        check({tag, "_func"},  32'(bus.func_out), 32'(NOP));
        check({tag, "_data"},  32'(bus.data_out), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_pc"},    32'(bus.pc_out), 0);
    endtask

    // Called at a falling edge; the write happens on the following rising edge.
    task automatic write_word(input int addr, input logic [17:0] w);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = AW'(addr);
        bus.prog_wdata = w;
        mem_model[addr] = w;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    function automatic void build_expect(input int stall_pc, input int stall_n);
        issue_t e;
        exp_q.delete();
        for (int pc = 0; pc < DEPTH; pc++) begin
            e.func = mem_model[pc][8:0];
            e.data = mem_model[pc][16:9];
            e.pc   = AW'(pc);
            for (int r = 0; r < ((pc == stall_pc) ? 1 + stall_n : 1); r++) exp_q.push_back(e);
            if (mem_model[pc][17]) break;
        end
    endfunction

    task automatic run(input string name, input int stall_pc, input int stall_n,
                       input bit wr_run, input bit wr_start, input logic [17:0] wr_word);
        int     rem    = stall_n;
        int     issued = 0;
        int     n_exp;
        bit     seen_done = 1'b0;
        bit     abort     = 1'b0;
        logic [AW-1:0] last_pc;
        issue_t e;

        build_expect(stall_pc, stall_n);
        n_exp   = exp_q.size();
        last_pc = exp_q[$].pc;
        bus.start = 1'b1;
        if (wr_start) begin
            bus.prog_we    = 1'b1;
            bus.prog_addr  = '0;
            bus.prog_wdata = wr_word;
            mem_model[0]   = wr_word;
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;

        for (int cyc = 0; cyc < 64 && !seen_done && !abort; cyc++) begin
            if (bus.issue_valid) begin
                issued++;
                if (exp_q.size() == 0) begin
                    check({name, "_extra_issue"}, 32'(bus.pc_out), 32'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check({name, "_func"}, 32'(bus.func_out), 32'(e.func));
                    check({name, "_data"}, 32'(bus.data_out), 32'(e.data));
                    check({name, "_pc"},   32'(bus.pc_out),   32'(e.pc));
                    check({name, "_busy"}, 32'(bus.busy), 1);
                end
                bus.stall = (rem > 0) && (bus.pc_out == AW'(stall_pc));
                if (bus.stall) rem--;
                if (wr_run && issued == 1) begin
                    bus.prog_we    = 1'b1;
                    bus.prog_addr  = AW'(2);
                    bus.prog_wdata = ~mem_model[2];
                end else begin
                    bus.prog_we = 1'b0;
                end
            end else if (bus.done) begin
                seen_done = 1'b1;
                bus.stall = 1'b0;
                bus.prog_we = 1'b0;
                check({name, "_done_func"}, 32'(bus.func_out), 32'(NOP));
                check({name, "_done_data"}, 32'(bus.data_out), 0);
                check({name, "_done_busy"}, 32'(bus.busy), 0);
                check({name, "_done_pc"},   32'(bus.pc_out), 32'(last_pc));
            end else begin
                check({name, "_issue_gap"}, 32'(bus.issue_valid), 1);
                abort = 1'b1;
            end
            @(negedge clk);
        end
        bus.stall   = 1'b0;
        bus.prog_we = 1'b0;
        if (!seen_done) check({name, "_done_timeout"}, 32'(seen_done), 1);
        check({name, "_done_pulse"}, 32'(bus.done), 0);
        check({name, "_idle_valid"}, 32'(bus.issue_valid), 0);
        check({name, "_issue_count"}, 32'(issued), 32'(n_exp));
        check({name, "_left_in_queue"}, 32'(exp_q.size()), 0);
    endtask

    initial begin
        bit     reached;
        issue_t e;

        rst_n          = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.start      = 1'b0;
        bus.stall      = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-word program ending in a halt word.
        write_word(0, {1'b0, 8'h05, 9'o100});
        write_word(1, {1'b0, 8'h07, 9'o101});
        write_word(2, {1'b1, 8'h00, 9'o201});
        run("basic", -1, 0, 1'b0, 1'b0, '0);
        run("stall", 1, 2, 1'b0, 1'b0, '0);
        run("wr_busy", -1, 0, 1'b1, 1'b0, '0);
        run("after_wr_busy", -1, 0, 1'b0, 1'b0, '0);

        // Reset in the middle of a run.
        build_expect(-1, 0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reached = 1'b0;
        for (int cyc = 0; cyc < 8 && !reached; cyc++) begin
            if (bus.issue_valid && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pre_reset_pc", 32'(bus.pc_out), 32'(e.pc));
                reached = (bus.pc_out == AW'(1));
            end
            if (!reached) @(negedge clk);
        end
        check("reach_pc1", 32'(reached), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("after_reset", -1, 0, 1'b0, 1'b0, '0);

        // Start and write to address 0 on the same edge.
        run("start_wr0", -1, 0, 1'b0, 1'b1, {1'b0, 8'hAA, 9'o300});
        run("new_word0", -1, 0, 1'b0, 1'b0, '0);

        // Full program with no halt: must stop at the last address.
        for (int i = 0; i < DEPTH; i++) write_word(i, {1'b0, 8'(8'h10 + i), 9'(9'h100 + i)});
        run("full", -1, 0, 1'b0, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
